// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO and sticky error flags.
// Bytes are sampled mid-bit from a two-flop synchronised rx line.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_W        = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             pop,
  input  logic             clear_errors,
  output logic             uart_inbound,
  output logic [7:0]       uart_data,
  output logic [PTR_W:0]   fifo_count,
  output logic             overrun,
  output logic             frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             rx_meta_r;
  logic             rx_s_r;
  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             push_r;
  logic             frame_error_r;
  logic             overrun_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  logic empty_s;
  logic full_s;
  logic do_push_s;
  logic do_pop_s;
  logic stop_fail_s;

  assign empty_s     = (count_r == {(PTR_W + 1){1'b0}});
  assign full_s      = (count_r == CNT_FULL);
  // A full FIFO still accepts a push when the consumer frees a slot in the same cycle.
  assign do_push_s   = push_r && (!full_s || pop);
  assign do_pop_s    = pop && !empty_s;
  assign stop_fail_s = (state_r == STOP) && (baud_cnt_r == FULL_M1) && !rx_s_r;

  assign uart_inbound = !empty_s;
  assign uart_data    = empty_s ? 8'h00 : mem_r[rd_ptr_r];
  assign fifo_count   = count_r;
  assign overrun      = overrun_r;
  assign frame_error  = frame_error_r;

  // Two-flop synchroniser for the asynchronous rx line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Frame deserialiser; push_r pulses for one cycle after a valid stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      push_r     <= 1'b0;
    end else begin
      push_r <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_cnt_r <= {CNT_W{1'b0}};
          if (!rx_s_r) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (baud_cnt_r == HALF_M1) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            state_r    <= rx_s_r ? IDLE : DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt_r == FULL_M1) begin
            baud_cnt_r         <= {CNT_W{1'b0}};
            shift_r[bit_idx_r] <= rx_s_r;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt_r == FULL_M1) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            state_r    <= IDLE;
            push_r     <= rx_s_r;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky frame error; a same-cycle set beats clear_errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error_r <= 1'b0;
    end else if (stop_fail_s) begin
      frame_error_r <= 1'b1;
    end else if (clear_errors) begin
      frame_error_r <= 1'b0;
    end else begin
      frame_error_r <= frame_error_r;
    end
  end

  // Sticky overrun: a push was dropped because the FIFO was full and not popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r <= 1'b0;
    end else if (push_r && full_s && !pop) begin
      overrun_r <= 1'b1;
    end else if (clear_errors) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + (PTR_W + 1)'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - (PTR_W + 1)'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with CLKS_PER_BIT=8.
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       pop;
  logic       clear_errors;
  logic       uart_inbound;
  logic [7:0] uart_data;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_error;

  int n_cmp;
  int n_err;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .pop          (pop),
    .clear_errors (clear_errors),
    .uart_inbound (uart_inbound),
    .uart_data    (uart_data),
    .fifo_count   (fifo_count),
    .overrun      (overrun),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 10-bit frame; entered and left 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks the head byte, then pops it with a one-cycle strobe.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, uart_data}, {24'h0, exp});
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    rx = 1'b1;
    pop = 1'b0;
    clear_errors = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inbound", {31'h0, uart_inbound}, 32'h0);
    check("rst_data", {24'h0, uart_data}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_flags", {30'h0, overrun, frame_error}, 32'h0);
    reset_n = 1'b1;
    idle(4);

    // 1: single frame latency and pop
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1;
        check("t1_not_yet", {31'h0, uart_inbound}, 32'h0);
        @(posedge clk);
        #1;
        check("t1_inbound", {31'h0, uart_inbound}, 32'h1);
      end
    join
    check("t1_count", {29'h0, fifo_count}, 32'h1);
    pop_check("t1_data", 8'hA5);
    check("t1_empty_inb", {31'h0, uart_inbound}, 32'h0);
    check("t1_empty_data", {24'h0, uart_data}, 32'h0);
    idle(4);

    // 2: overrun with five back-to-back frames
    for (int i = 1; i <= 5; i++) send_frame(i[7:0], 1'b1);
    check("t2_count", {29'h0, fifo_count}, 32'h4);
    check("t2_overrun", {31'h0, overrun}, 32'h1);
    for (int i = 1; i <= 4; i++) pop_check("t2_data", i[7:0]);
    check("t2_drained", {29'h0, fifo_count}, 32'h0);
    pop = 1'b1;
    @(posedge clk);
    #1;
    pop = 1'b0;
    check("t2_pop_empty", {29'h0, fifo_count}, 32'h0);
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
    check("t2_cleared", {31'h0, overrun}, 32'h0);

    // 3: bad stop bit, with clear_errors held across the setting edge
    fork
      send_frame(8'h3C, 1'b0);
      begin
        clear_errors = 1'b1;
        repeat (79) @(posedge clk);
        #1;
        clear_errors = 1'b0;
      end
    join
    check("t3_frame_err", {31'h0, frame_error}, 32'h1);
    check("t3_count", {29'h0, fifo_count}, 32'h0);
    idle(16);
    send_frame(8'h7E, 1'b1);
    check("t3_count2", {29'h0, fifo_count}, 32'h1);
    pop_check("t3_data", 8'h7E);
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
    check("t3_cleared", {31'h0, frame_error}, 32'h0);

    // 4: short glitch while idle
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    check("t4_count", {29'h0, fifo_count}, 32'h0);
    check("t4_flags", {30'h0, overrun, frame_error}, 32'h0);
    send_frame(8'h81, 1'b1);
    pop_check("t4_after", 8'h81);
    idle(4);

    // 5: push and pop on the same edge while full
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check("t5_full", {29'h0, fifo_count}, 32'h4);
    fork
      send_frame(8'hEE, 1'b1);
      begin
        repeat (79) @(posedge clk);
        #1;
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
      end
    join
    check("t5_count", {29'h0, fifo_count}, 32'h4);
    check("t5_overrun", {31'h0, overrun}, 32'h0);
    pop_check("t5_d0", 8'h22);
    pop_check("t5_d1", 8'h33);
    pop_check("t5_d2", 8'h44);
    pop_check("t5_d3", 8'hEE);
    check("t5_empty", {29'h0, fifo_count}, 32'h0);

    // 6: reset during DATA bit 4 with two bytes stored
    send_frame(8'hC3, 1'b1);
    send_frame(8'h3C, 1'b1);
    check("t6_stored", {29'h0, fifo_count}, 32'h2);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_inbound", {31'h0, uart_inbound}, 32'h0);
    check("t6_data", {24'h0, uart_data}, 32'h0);
    check("t6_count", {29'h0, fifo_count}, 32'h0);
    check("t6_flags", {30'h0, overrun, frame_error}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(16);
    check("t6_quiet", {29'h0, fifo_count}, 32'h0);
    send_frame(8'h5A, 1'b1);
    check("t6_count2", {29'h0, fifo_count}, 32'h1);
    pop_check("t6_data2", 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
